tile_number_renderer: RTL
=========================

// Module: tile_number_renderer
// PURPOSE
//   Renders the decimal value of one 2048 tile as glyph pixels; drives the digit font ROM and consumes its row output.
//   Converts the tile exponent to up to 5 BCD digits with a multi-cycle double-dabble FSM, once per frame.
//   Maps tile-local pixel coordinates to digit index, glyph row and glyph column, then produces a pipelined pixel_on to the VGA colour mux.
// PARAMETERS
//   TILE_W   128  tile width in pixels
//   TILE_H   128  tile height in pixels
//   GLYPH_W  16   glyph width in pixels; fixed by the 16-bit ROM row
//   GLYPH_H  32   glyph height in pixels; 16 ROM rows, each drawn on 2 lines
// PORTS
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous reset, active-high
//   frame_start  in   1   1-cycle pulse; starts a conversion when idle
//   tile_exp     in   4   0 = empty tile; 1..15 = value 2^tile_exp
//   pix_valid    in   1   tile_x/tile_y are valid this cycle
//   tile_x       in   7   tile-local pixel column, 0..TILE_W-1
//   tile_y       in   7   tile-local pixel row, 0..TILE_H-1
//   font_number  out  4   digit code to the font ROM
//   font_v_cnt   out  12  glyph line to the font ROM, 0..31
//   font_row     in   16  ROM row; bit 15 = leftmost pixel; 1-cycle ROM latency
//   busy         out  1   conversion in progress
//   pixel_on     out  1   glyph pixel lit
//   pixel_valid  out  1   pix_valid delayed to align with pixel_on
// BEHAVIOUR
//   Reset values: all outputs 0; digit regs 0; ndig 0; FSM in IDLE.
//   FSM IDLE->SHIFT: on frame_start while in IDLE. tile_exp is sampled that cycle; value = (exp==0) ? 0 : 1<<exp (16 bit).
//   SHIFT: 16 cycles, counter 15..0. Each cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//   COMMIT: 1 cycle; copies shadow BCD to display regs d4..d0 and computes ndig; then goes to IDLE.
//   busy=1 in SHIFT and COMMIT (17 cycles). New digits are visible the cycle busy falls.
//   frame_start while busy: ignored, no restart. tile_exp changes during a conversion have no effect.
//   Display regs change only in COMMIT, so rendering uses the previous digits during a conversion.
//   ndig: exp==0 -> 0, nothing drawn. Otherwise ndig = count of significant digits (1..5), no leading zeros.
//   Text box: TY = (TILE_H-GLYPH_H)/2 = 48; X0 = (TILE_W - ndig*GLYPH_W)/2, 11-bit unsigned arithmetic.
//   hit = pix_valid & ndig!=0 & TY<=tile_y<TY+32 & X0<=tile_x<X0+ndig*16.
//   k = (tile_x-X0)>>4 selects the k-th digit from the MSD; col = (tile_x-X0)[3:0].
//   Stage A (edge t+1): font_number = selected digit; font_v_cnt = {7'b0, tile_y-TY}; col_a and hit_a registered.
//     On a miss: font_number=0 and font_v_cnt=0.
//   Stage B (edge t+2): ROM returns font_row; col_b and hit_b registered.
//   Stage C (edge t+3): pixel_on = hit_b & font_row[15-col_b]; pixel_valid = delayed pix_valid.
//   Pixel latency is exactly 3 cycles; the pipeline never stalls and accepts 1 pixel/cycle.
//   Async rst mid-conversion: FSM to IDLE, busy=0, digits cleared; pipeline flushed to 0.
// CONFIGURATION
//   TNR_LEADING_ZERO_EN defined: ndig=5 always for exp!=0; leading zeros drawn (exp=1 -> "00002"); X0 = 24.
//   Not defined: leading zeros suppressed as above.
//   exp==0 draws nothing in both modes.
// TESTING
//   1. Assert rst mid-SHIFT -> busy=0, pixel_on=0, pixel_valid=0 immediately. After release, every pixel is off until the next conversion.
//   2. exp=11, pulse frame_start -> busy high 17 cycles; digits 2,0,4,8; ndig=4; X0=32.
//   3. After test 2, pixel (34,52) -> font_number=2, font_v_cnt=4 at t+1; pixel_on=1 at t+3.
//      Pixel (32,52) -> pixel_on=0. Pixel (31,52) -> hit=0, pixel_on=0.
//   4. exp=15 -> 3,2,7,6,8 and X0=24. exp=1 -> single '2' at X0=56. exp=0 -> pixel_on=0 over a full 128x128 sweep.
//   5. Pulse frame_start again at busy cycle 5 and change tile_exp -> no restart; result is from the original exp.
//      Rendering during busy still shows the old digits.
//   6. Stream 128 consecutive pixels of row 60 -> pixel_valid is pix_valid delayed by exactly 3 cycles.
//      pixel_on matches the golden glyph bitmap at each column.

Source files
------------

// File: rtl/tile_number_renderer.sv
// Renders the decimal value of one 2048 tile as font-ROM glyph pixels.
// Optional feature macro: TNR_LEADING_ZERO_EN (always draw five digits, leading zeros included).
module tile_number_renderer #(
  parameter int TILE_W  = 128,
  parameter int TILE_H  = 128,
  parameter int GLYPH_W = 16,
  parameter int GLYPH_H = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [3:0]  tile_exp,
  input  logic        pix_valid,
  input  logic [6:0]  tile_x,
  input  logic [6:0]  tile_y,
  output logic [3:0]  font_number,
  output logic [11:0] font_v_cnt,
  input  logic [15:0] font_row,
  output logic        busy,
  output logic        pixel_on,
  output logic        pixel_valid
);

  localparam int TY = (TILE_H - GLYPH_H) / 2;
  localparam int CW = $clog2(GLYPH_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [19:0] bcd_reg, bcd_next;
  logic [15:0] bin_reg, bin_next;
  logic        zero_reg, zero_next;
  logic [19:0] bcd_adj;
  logic        commit;
  logic [2:0]  ndig_calc;

  logic [19:0] disp_bcd_reg;
  logic [2:0]  ndig_reg;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      bcd_reg   <= 20'd0;
      bin_reg   <= 16'd0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bcd_reg   <= bcd_next;
      bin_reg   <= bin_next;
      zero_reg  <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bcd_next   = bcd_reg;
    bin_next   = bin_reg;
    zero_next  = zero_reg;
    commit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (frame_start) begin
          state_next = S_SHIFT;
          cnt_next   = 4'd15;
          bcd_next   = 20'd0;
          bin_next   = (tile_exp == 4'd0) ? 16'd0 : (16'd1 << tile_exp);
          zero_next  = (tile_exp == 4'd0);
        end
      end
      S_SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd0) begin
          state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);

  // Digit count from the finished shadow BCD: position of the highest non-zero nibble.
  always_comb begin
    ndig_calc = 3'd0;
`ifdef TNR_LEADING_ZERO_EN
    ndig_calc = 3'd5;
`else
    for (int i = 0; i < 5; i++) begin
      if (bcd_reg[i*4 +: 4] != 4'd0) begin
        ndig_calc = 3'(i + 1);
      end
    end
`endif
    if (zero_reg) begin
      ndig_calc = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd_reg <= 20'd0;
      ndig_reg     <= 3'd0;
    end else if (commit) begin
      disp_bcd_reg <= bcd_reg;
      ndig_reg     <= ndig_calc;
    end
  end

  // Pixel address decode against the centred text box.
  logic [10:0] text_w, x0, px, py, rel_x;
  logic [4:0]  v_line;
  logic [2:0]  k, sel;
  logic [3:0]  sel_digit;
  logic        hit;

  always_comb begin
    text_w = {8'd0, ndig_reg} * 11'(GLYPH_W);
    x0     = (11'(TILE_W) - text_w) >> 1;
    px     = {4'd0, tile_x};
    py     = {4'd0, tile_y};
    rel_x  = px - x0;
    v_line = 5'(py - 11'(TY));
    k      = rel_x[CW +: 3];
    sel    = ndig_reg - 3'd1 - k;
    hit    = pix_valid && (ndig_reg != 3'd0) &&
             (py >= 11'(TY)) && (py < 11'(TY + GLYPH_H)) &&
             (px >= x0) && (rel_x < text_w);
  end

  always_comb begin
    sel_digit = 4'd0;
    case (sel)
      3'd0: sel_digit = disp_bcd_reg[3:0];
      3'd1: sel_digit = disp_bcd_reg[7:4];
      3'd2: sel_digit = disp_bcd_reg[11:8];
      3'd3: sel_digit = disp_bcd_reg[15:12];
      3'd4: sel_digit = disp_bcd_reg[19:16];
      default: sel_digit = 4'd0;
    endcase
  end

  logic [3:0] col_a_reg, col_b_reg;
  logic       hit_a_reg, hit_b_reg;
  logic       valid_a_reg, valid_b_reg;

  // Three fixed stages: address to ROM, ROM latency, bit select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_number <= 4'd0;
      font_v_cnt  <= 12'd0;
      col_a_reg   <= 4'd0;
      hit_a_reg   <= 1'b0;
      valid_a_reg <= 1'b0;
      col_b_reg   <= 4'd0;
      hit_b_reg   <= 1'b0;
      valid_b_reg <= 1'b0;
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      font_number <= hit ? sel_digit : 4'd0;
      font_v_cnt  <= hit ? {7'd0, v_line} : 12'd0;
      col_a_reg   <= hit ? rel_x[3:0] : 4'd0;
      hit_a_reg   <= hit;
      valid_a_reg <= pix_valid;
      col_b_reg   <= col_a_reg;
      hit_b_reg   <= hit_a_reg;
      valid_b_reg <= valid_a_reg;
      pixel_on    <= hit_b_reg & font_row[4'd15 - col_b_reg];
      pixel_valid <= valid_b_reg;
    end
  end

endmodule
